// File: rtl/codec_intf_if.sv
// codec_intf_if: serial-audio and sample-word signals between codec_intf and its neighbours.
// master is the codec_intf side; slave is the CODEC/datapath side.
interface codec_intf_if;
   logic        SDout;
   logic [15:0] lft_out;
   logic [15:0] rht_out;
   logic        MCLK;
   logic        SCLK;
   logic        LRCLK;
   logic        SDin;
   logic        RSTn;
   logic [15:0] lft_in;
   logic [15:0] rht_in;
   logic        valid;

   modport master (
      input  SDout, lft_out, rht_out,
      output MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
   );

   modport slave (
      output SDout, lft_out, rht_out,
      input  MCLK, SCLK, LRCLK, SDin, RSTn, lft_in, rht_in, valid
   );
endinterface

// File: rtl/codec_intf.sv
// codec_intf: CS4272 clock generation and left-justified 16-bit serial audio port.
// One 10-bit frame counter drives every clock, the RX deserializer and the TX serializer.
module codec_intf (
   input logic          clk,
   input logic          rst,
   codec_intf_if.master bus
);

   localparam logic [9:0] CntLeftLast  = 10'd495;   // SCLK rise carrying the 16th left bit
   localparam logic [9:0] CntRightLast = 10'd1007;  // SCLK rise carrying the 16th right bit
   localparam logic [9:0] CntHalfEnd   = 10'd511;
   localparam logic [9:0] CntFrameEnd  = 10'd1023;

   logic [9:0]  cnt;
   logic        rstn_q;
   logic [15:0] rx_shift;
   logic [15:0] lft_hold;
   logic [15:0] lft_in_q;
   logic [15:0] rht_in_q;
   logic        valid_q;
   logic [15:0] tx_shift;
   logic [15:0] rht_hold;

   logic        sclk_rise;
   logic        sclk_fall;
   logic [15:0] rx_next;

   assign sclk_rise = (cnt[4:0] == 5'd15);
   assign sclk_fall = (cnt[4:0] == 5'd31);
   // Last bit is folded in on the same edge it is sampled.
   assign rx_next   = {rx_shift[14:0], bus.SDout};

   // Frame counter and CODEC reset: RSTn releases at the first frame boundary after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         rstn_q <= 1'b0;
      end else begin
         cnt <= cnt + 10'd1;
         if (cnt == CntFrameEnd) rstn_q <= 1'b1;
      end
   end

   // Receive: shift on SCLK rise, park left word, publish the pair with a one-cycle strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_shift <= '0;
         lft_hold <= '0;
         lft_in_q <= '0;
         rht_in_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (sclk_rise) rx_shift <= rx_next;
         if (cnt == CntLeftLast) lft_hold <= rx_next;
         // rstn_q only changes at frame boundaries, so it marks frames that began out of reset.
         if (cnt == CntRightLast && rstn_q) begin
            lft_in_q <= lft_hold;
            rht_in_q <= rx_next;
            valid_q  <= 1'b1;
         end
      end
   end

   // Transmit: both words captured together at frame end so the sent pair never mixes updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift <= '0;
         rht_hold <= '0;
      end else if (cnt == CntFrameEnd) begin
         tx_shift <= bus.lft_out;
         rht_hold <= bus.rht_out;
      end else if (cnt == CntHalfEnd) begin
         tx_shift <= rht_hold;
      end else if (sclk_fall) begin
         tx_shift <= {tx_shift[14:0], 1'b0};
      end
   end

   assign bus.MCLK   = cnt[1];
   assign bus.SCLK   = cnt[4];
   assign bus.LRCLK  = cnt[9];
   assign bus.SDin   = tx_shift[15];
   assign bus.RSTn   = rstn_q;
   assign bus.lft_in = lft_in_q;
   assign bus.rht_in = rht_in_q;
   assign bus.valid  = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: frame-level CODEC model driving SDout and predicting every codec_intf output.
module tb_codec_intf;

   localparam int NF = 16;  // frames of model history per reset

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   codec_intf_if bus ();
   codec_intf dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;
   int t;  // clocks since reset release; sampled on negedge

   logic [15:0] sl [NF];     // words the CODEC model sends per frame
   logic [15:0] sr [NF];
   logic [15:0] otx_l [NF];  // lft_out/rht_out present at the end of each frame
   logic [15:0] otx_r [NF];
   logic [15:0] lo_v, ro_v;
   bit          loop_mode;

   function automatic logic exp_mclk(int tt);  return ((tt / 2) % 2) == 1;   endfunction
   function automatic logic exp_sclk(int tt);  return ((tt / 16) % 2) == 1;  endfunction
   function automatic logic exp_lrclk(int tt); return ((tt / 512) % 2) == 1; endfunction
   function automatic logic exp_rstn(int tt);  return tt >= 1024;            endfunction
   function automatic logic exp_valid(int tt);
      return (tt % 1024 == 1008) && (tt >= 1024);
   endfunction

   function automatic logic exp_sdin(int tt);
      int f;
      int pos;
      logic [15:0] w;
      f   = tt / 1024;
      pos = tt % 1024;
      if (f == 0) return 1'b0;
      w = (pos < 512) ? otx_l[f-1] : otx_r[f-1];
      return w[15 - ((pos % 512) / 32)];
   endfunction

   // Drive inputs for the coming edge, record what the DUT will capture, advance one clock.
   task automatic step();
      int f;
      int pos;
      logic [15:0] w;
      f   = t / 1024;
      pos = t % 1024;
      if (f >= NF) begin
         $display("FAIL model_range t=%0d frame %0d beyond model history %0d", t, f, NF);
         fails++;
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $fatal(1, "model history exceeded");
      end
      if (loop_mode && pos == 0 && f >= 2) begin
         sl[f] = otx_l[f-1];
         sr[f] = otx_r[f-1];
      end
      if (loop_mode && f >= 2) begin
         bus.SDout = bus.SDin;
      end else begin
         w = (pos < 512) ? sl[f] : sr[f];
         bus.SDout = w[15 - ((pos % 512) / 32)];
      end
      if (loop_mode && f >= 1) begin
         bus.lft_out = bus.lft_in;
         bus.rht_out = bus.rht_in;
      end else begin
         bus.lft_out = lo_v;
         bus.rht_out = ro_v;
      end
      if (pos == 1023) begin
         if (loop_mode && f >= 1) begin
            otx_l[f] = sl[f];
            otx_r[f] = sr[f];
         end else begin
            otx_l[f] = lo_v;
            otx_r[f] = ro_v;
         end
      end
      @(negedge clk);
      t++;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      loop_mode   = 1'b0;
      lo_v        = '0;
      ro_v        = '0;
      bus.SDout   = 1'b0;
      bus.lft_out = '0;
      bus.rht_out = '0;
      for (int i = 0; i < NF; i++) begin
         otx_l[i] = '0;
         otx_r[i] = '0;
         sl[i]    = '0;
         sr[i]    = '0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      t   = 0;
   endtask

   task automatic test_reset();
      logic [37:0] obs;
      rst         = 1'b1;
      bus.SDout   = 1'b1;
      bus.lft_out = 16'hFFFF;
      bus.rht_out = 16'hFFFF;
      repeat (3) @(negedge clk);
      obs = {bus.MCLK, bus.SCLK, bus.LRCLK, bus.SDin, bus.RSTn, bus.valid, bus.lft_in, bus.rht_in};
      tests++;
      if (obs !== 38'd0) begin
         $display("FAIL reset_state got %h exp 0", obs);
         fails++;
      end
      do_reset();
      tests++;
      if ({bus.MCLK, bus.SCLK, bus.LRCLK, bus.RSTn, bus.valid} !== 5'b0) begin
         $display("FAIL reset_release got %b exp 00000",
                  {bus.MCLK, bus.SCLK, bus.LRCLK, bus.RSTn, bus.valid});
         fails++;
      end
   endtask

   task automatic test_clocks();
      int first_valid;
      int rstn_rise;
      do_reset();
      first_valid = -1;
      rstn_rise   = -1;
      for (int i = 0; i < 2100; i++) begin
         tests++;
         if ({bus.MCLK, bus.SCLK, bus.LRCLK} !== {exp_mclk(t), exp_sclk(t), exp_lrclk(t)}) begin
            $display("FAIL clocks t=%0d got %b exp %b", t, {bus.MCLK, bus.SCLK, bus.LRCLK},
                     {exp_mclk(t), exp_sclk(t), exp_lrclk(t)});
            fails++;
         end
         tests++;
         if (bus.RSTn !== exp_rstn(t)) begin
            $display("FAIL rstn t=%0d got %b exp %b", t, bus.RSTn, exp_rstn(t));
            fails++;
         end
         tests++;
         if (bus.valid !== exp_valid(t)) begin
            $display("FAIL valid t=%0d got %b exp %b", t, bus.valid, exp_valid(t));
            fails++;
         end
         if (bus.valid === 1'b1 && first_valid < 0) first_valid = t;
         if (bus.RSTn === 1'b1 && rstn_rise < 0) rstn_rise = t;
         step();
      end
      tests++;
      if (first_valid != 2032) begin
         $display("FAIL first_valid got %0d exp 2032", first_valid);
         fails++;
      end
      tests++;
      if (rstn_rise != 1024) begin
         $display("FAIL rstn_rise got %0d exp 1024", rstn_rise);
         fails++;
      end
   endtask

   task automatic test_rx_pattern();
      int nvalid;
      do_reset();
      for (int i = 0; i < NF; i++) begin
         sl[i] = 16'h8001;
         sr[i] = 16'h7FFE;
      end
      nvalid = 0;
      for (int i = 0; i < 5 * 1024 + 8; i++) begin
         tests++;
         if (bus.valid !== exp_valid(t)) begin
            $display("FAIL rx_valid t=%0d got %b exp %b", t, bus.valid, exp_valid(t));
            fails++;
         end
         if (exp_valid(t)) begin
            nvalid++;
            tests++;
            if ({bus.lft_in, bus.rht_in} !== {16'h8001, 16'h7FFE}) begin
               $display("FAIL rx_pair t=%0d got %h/%h exp 8001/7ffe", t, bus.lft_in, bus.rht_in);
               fails++;
            end
         end
         if (t > 2032) begin
            tests++;
            if (bus.lft_in !== 16'h8001) begin
               $display("FAIL rx_stable t=%0d got %h exp 8001", t, bus.lft_in);
               fails++;
            end
         end
         step();
      end
      tests++;
      if (nvalid != 4) begin
         $display("FAIL rx_count got %0d exp 4", nvalid);
         fails++;
      end
   endtask

   task automatic test_tx_pattern();
      do_reset();
      lo_v = 16'hA5C3;
      ro_v = 16'h0F0F;
      for (int i = 0; i < 3 * 1024; i++) begin
         tests++;
         if (bus.SDin !== exp_sdin(t)) begin
            $display("FAIL tx_bit t=%0d got %b exp %b", t, bus.SDin, exp_sdin(t));
            fails++;
         end
         step();
      end
   endtask

   task automatic test_tx_update();
      do_reset();
      lo_v = 16'($urandom);
      ro_v = 16'($urandom);
      for (int i = 0; i < 5 * 1024; i++) begin
         if (t % 1024 == 500 || t % 1024 == 1020) begin
            lo_v = 16'($urandom);
            ro_v = 16'($urandom);
         end
         tests++;
         if (bus.SDin !== exp_sdin(t)) begin
            $display("FAIL tx_update t=%0d got %b exp %b", t, bus.SDin, exp_sdin(t));
            fails++;
         end
         step();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < NF; i++) begin
         sl[i] = 16'($urandom);
         sr[i] = 16'($urandom);
      end
      for (int i = 0; i < 6 * 1024; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            lo_v = 16'($urandom);
            ro_v = 16'($urandom);
         end
         tests++;
         if (bus.SDin !== exp_sdin(t)) begin
            $display("FAIL rand_sdin t=%0d got %b exp %b", t, bus.SDin, exp_sdin(t));
            fails++;
         end
         tests++;
         if (bus.valid !== exp_valid(t)) begin
            $display("FAIL rand_valid t=%0d got %b exp %b", t, bus.valid, exp_valid(t));
            fails++;
         end
         if (exp_valid(t)) begin
            tests++;
            if ({bus.lft_in, bus.rht_in} !== {sl[t/1024], sr[t/1024]}) begin
               $display("FAIL rand_pair t=%0d got %h/%h exp %h/%h", t, bus.lft_in, bus.rht_in,
                        sl[t/1024], sr[t/1024]);
               fails++;
            end
         end
         step();
      end
   endtask

   task automatic test_mid_reset();
      logic [37:0] obs;
      do_reset();
      for (int i = 0; i < NF; i++) begin
         sl[i] = 16'($urandom);
         sr[i] = 16'($urandom);
      end
      lo_v = 16'hFFFF;
      ro_v = 16'hFFFF;
      while (t < 2 * 1024 + 700) step();
      // One-cycle pulse on the edge where cnt==700, mid right-channel reception.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t   = 0;
      for (int i = 0; i < NF; i++) begin
         otx_l[i] = '0;
         otx_r[i] = '0;
      end
      obs = {bus.MCLK, bus.SCLK, bus.LRCLK, bus.SDin, bus.RSTn, bus.valid, bus.lft_in, bus.rht_in};
      tests++;
      if (obs !== 38'd0) begin
         $display("FAIL mid_reset_state got %h exp 0", obs);
         fails++;
      end
      for (int i = 0; i < 2100; i++) begin
         tests++;
         if (bus.RSTn !== exp_rstn(t)) begin
            $display("FAIL mid_rstn t=%0d got %b exp %b", t, bus.RSTn, exp_rstn(t));
            fails++;
         end
         tests++;
         if (bus.valid !== exp_valid(t)) begin
            $display("FAIL mid_valid t=%0d got %b exp %b", t, bus.valid, exp_valid(t));
            fails++;
         end
         tests++;
         if (bus.SDin !== exp_sdin(t)) begin
            $display("FAIL mid_sdin t=%0d got %b exp %b", t, bus.SDin, exp_sdin(t));
            fails++;
         end
         if (exp_valid(t)) begin
            tests++;
            if ({bus.lft_in, bus.rht_in} !== {sl[t/1024], sr[t/1024]}) begin
               $display("FAIL mid_pair t=%0d got %h/%h exp %h/%h", t, bus.lft_in, bus.rht_in,
                        sl[t/1024], sr[t/1024]);
               fails++;
            end
         end
         step();
      end
   endtask

   task automatic test_loopback();
      do_reset();
      sl[0] = 16'h1234;
      sr[0] = 16'hFEDC;
      sl[1] = 16'h1234;
      sr[1] = 16'hFEDC;
      loop_mode = 1'b1;
      for (int i = 0; i < 5 * 1024 + 16; i++) begin
         tests++;
         if (bus.valid !== exp_valid(t)) begin
            $display("FAIL loop_valid t=%0d got %b exp %b", t, bus.valid, exp_valid(t));
            fails++;
         end
         if (exp_valid(t)) begin
            tests++;
            if ({bus.lft_in, bus.rht_in} !== {16'h1234, 16'hFEDC}) begin
               $display("FAIL loop_pair t=%0d got %h/%h exp 1234/fedc", t, bus.lft_in, bus.rht_in);
               fails++;
            end
         end
         step();
      end
      loop_mode = 1'b0;
   endtask

   initial begin
      bus.SDout   = 1'b0;
      bus.lft_out = '0;
      bus.rht_out = '0;
      loop_mode   = 1'b0;
      lo_v        = '0;
      ro_v        = '0;
      t           = 0;
      test_reset();
      test_clocks();
      test_rx_pattern();
      test_tx_pattern();
      test_tx_update();
      test_random();
      test_mid_reset();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
